// File: rtl/instr_mem_pkg.sv
// Shared types and defaults for the field-loadable instruction store.
package instr_mem_pkg;

    typedef enum logic [0:0] {
        RUN  = 1'b0,
        LOAD = 1'b1
    } state_e;

    localparam int unsigned DEF_AW    = 8;
    localparam int unsigned DEF_IW    = 6;
    localparam int unsigned DEF_LW    = 2;
    localparam int unsigned DEF_DEPTH = 64;

    // All-ones pattern of iw bits, right-aligned in a 64-bit container
    function automatic logic [63:0] fill_value(input int unsigned iw);
        logic [63:0] v;
        v = 64'd0;
        for (int unsigned i = 0; i < 64; i++) begin
            if (i < iw) begin
                v[i] = 1'b1;
            end else begin
                v[i] = 1'b0;
            end
        end
        return v;
    endfunction

endpackage

// File: rtl/instr_word_assembler.sv
// Collects LW-bit chunks (least significant first) into IW-bit words.
// word/word_done are combinational so the owner can commit the word on the
// same edge that accepts the final chunk; an early chunk_last pads the
// remaining upper slots with FILL.
module instr_word_assembler
    import instr_mem_pkg::*;
#(
    parameter int unsigned    IW   = DEF_IW,
    parameter int unsigned    LW   = DEF_LW,
    parameter logic [IW-1:0]  FILL = IW'(fill_value(IW))
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clear,
    input  logic          chunk_valid,
    input  logic [LW-1:0] chunk_data,
    input  logic          chunk_last,
    output logic          word_done,
    output logic [IW-1:0] word
);

    localparam int unsigned   NS        = IW / LW;
    localparam int unsigned   SW        = (NS > 1) ? $clog2(NS) : 1;
    localparam logic [SW-1:0] LAST_SLOT = SW'(NS - 1);

    logic [SW-1:0] slot_q, slot_d;
    logic [IW-1:0] asm_q, asm_d;
    logic [IW-1:0] word_s;
    logic          word_done_s;

    // Merge held lower slots, the incoming chunk and FILL for upper slots
    always_comb begin
        word_s = FILL;
        for (int i = 0; i < int'(NS); i++) begin
            if (i < int'(slot_q)) begin
                word_s[i*LW +: LW] = asm_q[i*LW +: LW];
            end else if (i == int'(slot_q)) begin
                word_s[i*LW +: LW] = chunk_data;
            end else begin
                word_s[i*LW +: LW] = FILL[i*LW +: LW];
            end
        end
        word_done_s = chunk_valid && ((slot_q == LAST_SLOT) || chunk_last);
    end

    // Slot counter and assembly register next-state
    always_comb begin
        slot_d = slot_q;
        asm_d  = asm_q;
        if (clear) begin
            slot_d = {SW{1'b0}};
            asm_d  = FILL;
        end else if (word_done_s) begin
            slot_d = {SW{1'b0}};
            asm_d  = FILL;
        end else if (chunk_valid) begin
            slot_d = slot_q + {{(SW-1){1'b0}}, 1'b1};
            asm_d  = word_s;
        end else begin
            slot_d = slot_q;
            asm_d  = asm_q;
        end
    end

    // Slot counter and assembly register state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot_q <= {SW{1'b0}};
            asm_q  <= FILL;
        end else begin
            slot_q <= slot_d;
            asm_q  <= asm_d;
        end
    end

    assign word      = word_s;
    assign word_done = word_done_s;

endmodule

// File: rtl/instr_mem_loadable.sv
// Field-loadable instruction store: flop array read combinationally by the
// CPU, written serially through instr_word_assembler while busy is high.
// Optional feature macro: INSTR_MEM_CHECKSUM_EN (XOR checksum of loaded words).
module instr_mem_loadable
    import instr_mem_pkg::*;
#(
    parameter int unsigned   AW    = DEF_AW,
    parameter int unsigned   IW    = DEF_IW,
    parameter int unsigned   DEPTH = DEF_DEPTH,
    parameter int unsigned   LW    = DEF_LW,
    parameter logic [IW-1:0] FILL  = IW'(fill_value(IW))
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [AW-1:0] address,
    output logic [IW-1:0] instruction,
    input  logic          load_start,
    input  logic          load_valid,
    input  logic [LW-1:0] load_data,
    input  logic          load_last,
    output logic          busy,
    output logic [AW:0]   word_count,
    output logic [IW-1:0] checksum
);

    localparam int unsigned PW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);
    localparam logic [AW:0] LAST_W  = (AW+1)'(DEPTH - 1);

    generate
        if ((IW % LW) != 0) begin : g_bad_lw
            $error("instr_mem_loadable: IW must be a multiple of LW");
        end
        if (DEPTH > (1 << AW)) begin : g_bad_depth
            $error("instr_mem_loadable: DEPTH exceeds the address space");
        end
    endgenerate

    state_e        state_q, state_d;
    logic [AW:0]   word_count_q, word_count_d;
    logic [IW-1:0] mem_q [DEPTH];
    logic [IW-1:0] mem_d [DEPTH];
    logic          chunk_valid_s;
    logic          word_done_s;
    logic [IW-1:0] word_s;
    logic          mem_we_s;
    logic          busy_s;
    logic [PW-1:0] wr_idx_s;

    // A chunk is only taken while loading; a same-cycle start discards it
    assign chunk_valid_s = (state_q == LOAD) && load_valid && !load_start;
    assign mem_we_s      = word_done_s && (word_count_q < DEPTH_W);
    assign wr_idx_s      = word_count_q[PW-1:0];

    instr_word_assembler #(
        .IW   (IW),
        .LW   (LW),
        .FILL (FILL)
    ) u_asm (
        .clk         (clk),
        .rst_n       (rst_n),
        .clear       (load_start),
        .chunk_valid (chunk_valid_s),
        .chunk_data  (load_data),
        .chunk_last  (load_last),
        .word_done   (word_done_s),
        .word        (word_s)
    );

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state: a load ends on its last chunk or when the top word fills
    always_comb begin
        state_d = state_q;
        case (state_q)
            RUN: begin
                if (load_start) begin
                    state_d = LOAD;
                end else begin
                    state_d = RUN;
                end
            end
            LOAD: begin
                if (load_start) begin
                    state_d = LOAD;
                end else if (word_done_s && (load_last || (word_count_q == LAST_W))) begin
                    state_d = RUN;
                end else begin
                    state_d = LOAD;
                end
            end
            default: state_d = RUN;
        endcase
    end

    // FSM outputs
    always_comb begin
        case (state_q)
            LOAD:    busy_s = 1'b1;
            RUN:     busy_s = 1'b0;
            default: busy_s = 1'b0;
        endcase
    end

    // Memory write and word counter (which doubles as the write pointer)
    always_comb begin
        mem_d        = mem_q;
        word_count_d = word_count_q;
        if (load_start) begin
            word_count_d = {(AW+1){1'b0}};
        end else if (mem_we_s) begin
            mem_d[wr_idx_s] = word_s;
            word_count_d    = word_count_q + {{AW{1'b0}}, 1'b1};
        end else begin
            word_count_d = word_count_q;
        end
    end

    // Memory array and word counter state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= FILL;
            end
            word_count_q <= {(AW+1){1'b0}};
        end else begin
            mem_q        <= mem_d;
            word_count_q <= word_count_d;
        end
    end

    // CPU read port: FILL while loading or outside the implemented range
    always_comb begin
        if (busy_s) begin
            instruction = FILL;
        end else if ({1'b0, address} >= DEPTH_W) begin
            instruction = FILL;
        end else begin
            instruction = mem_q[address[PW-1:0]];
        end
    end

`ifdef INSTR_MEM_CHECKSUM_EN
    logic [IW-1:0] checksum_q, checksum_d;

    // XOR accumulation of every committed word, cleared by a load start
    always_comb begin
        if (load_start) begin
            checksum_d = {IW{1'b0}};
        end else if (mem_we_s) begin
            checksum_d = checksum_q ^ word_s;
        end else begin
            checksum_d = checksum_q;
        end
    end

    // Checksum accumulator state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            checksum_q <= {IW{1'b0}};
        end else begin
            checksum_q <= checksum_d;
        end
    end

    assign checksum = checksum_q;
`else
    assign checksum = {IW{1'b0}};
`endif

    assign busy       = busy_s;
    assign word_count = word_count_q;

endmodule
